// File: rtl/systolic_array_ctrl_nxm_pkg.sv
// Shared definitions for the GEMM tile engine: controller states, default widths
// and a width helper that never returns zero.
package gemma_acc_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int ACCUM_WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN
    } state_e;

    // Index width for n items; a single item still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_array_ctrl_nxm_if.sv
// Control, operand-stream and result-stream bundle of the GEMM tile engine.
// The engine uses the slave view; the feeding/draining logic uses the master view.
interface systolic_array_ctrl_nxm_if #(
    parameter int ROWS        = 16,
    parameter int COLS        = 16,
    parameter int DATA_WIDTH  = gemma_acc_pkg::DATA_WIDTH_DEF,
    parameter int ACCUM_WIDTH = gemma_acc_pkg::ACCUM_WIDTH_DEF,
    parameter int K_MAX       = 4096
) ();
    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = gemma_acc_pkg::clog2_min1(ROWS);

    logic                        start;
    logic [KW-1:0]               k_len;
    logic                        busy;
    logic                        in_valid;
    logic                        in_ready;
    logic [ROWS*DATA_WIDTH-1:0]  a_col;
    logic [COLS*DATA_WIDTH-1:0]  b_row;
    logic                        out_valid;
    logic                        out_ready;
    logic [RW-1:0]               out_row;
    logic [COLS*ACCUM_WIDTH-1:0] out_data;
    logic                        done;

    modport master (
        output start, k_len, in_valid, a_col, b_row, out_ready,
        input  busy, in_ready, out_valid, out_row, out_data, done
    );

    modport slave (
        input  start, k_len, in_valid, a_col, b_row, out_ready,
        output busy, in_ready, out_valid, out_row, out_data, done
    );
endinterface

// File: rtl/systolic_array_ctrl_nxm_pe.sv
// Output-stationary INT8 processing element: forwards operands east/south one
// cycle later and accumulates the signed product when both lanes are valid.
module pe_int8 #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          accum_reset_i,
    input  logic [DATA_WIDTH-1:0]         west_data_i,
    input  logic                          west_valid_i,
    input  logic [DATA_WIDTH-1:0]         north_data_i,
    input  logic                          north_valid_i,
    output logic [DATA_WIDTH-1:0]         east_data_o,
    output logic                          east_valid_o,
    output logic [DATA_WIDTH-1:0]         south_data_o,
    output logic                          south_valid_o,
    output logic signed [ACCUM_WIDTH-1:0] acc_o
);
    logic                          mac_en;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]         east_data_q, south_data_q;
    logic                          east_valid_q, south_valid_q;
    logic signed [ACCUM_WIDTH-1:0] acc_q;

    assign mac_en = west_valid_i & north_valid_i;
    assign prod   = $signed(west_data_i) * $signed(north_data_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            east_data_q   <= '0;
            east_valid_q  <= 1'b0;
            south_data_q  <= '0;
            south_valid_q <= 1'b0;
            acc_q         <= '0;
        end else begin
            east_data_q   <= west_data_i;
            east_valid_q  <= west_valid_i;
            south_data_q  <= north_data_i;
            south_valid_q <= north_valid_i;
            // Product is sign-extended; the sum wraps in two's complement.
            if (accum_reset_i) acc_q <= '0;
            else if (mac_en)   acc_q <= acc_q + ACCUM_WIDTH'(prod);
        end
    end

    assign east_data_o   = east_data_q;
    assign east_valid_o  = east_valid_q;
    assign south_data_o  = south_data_q;
    assign south_valid_o = south_valid_q;
    assign acc_o         = acc_q;
endmodule

// File: rtl/systolic_array_ctrl_nxm_skew.sv
// Fixed-latency register chain used to skew one operand lane; a depth of zero
// degenerates to a plain wire.
module skew_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);
    genvar gi;

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst;
            assign out_o       = in_i;
        end else begin : g_chain
            logic [WIDTH-1:0] stage_q [DEPTH];
            for (gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk) begin
                        if (rst) stage_q[gi] <= '0;
                        else     stage_q[gi] <= in_i;
                    end
                end else begin : g_body
                    always_ff @(posedge clk) begin
                        if (rst) stage_q[gi] <= '0;
                        else     stage_q[gi] <= stage_q[gi-1];
                    end
                end
            end
            assign out_o = stage_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/systolic_array_ctrl_nxm.sv
// ROWSxCOLS output-stationary INT8 GEMM tile engine: skews the operand streams,
// runs the K loop, flushes the grid and drains C one row at a time.
module systolic_array_ctrl_nxm
    import gemma_acc_pkg::*;
#(
    parameter int ROWS        = 16,
    parameter int COLS        = 16,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF,
    parameter int K_MAX       = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    systolic_array_ctrl_nxm_if.slave bus
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = clog2_min1(ROWS);
    localparam int FW = $clog2(ROWS + COLS + 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic [KW-1:0] beat_cnt_q, beat_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic          done_q, done_d;
    logic          accum_clear, beat_fire, row_fire;

    assign accum_clear = (state_q == CLEAR);
    assign beat_fire   = (state_q == FEED) && bus.in_valid;
    assign row_fire    = (state_q == DRAIN) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            row_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            row_q       <= row_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        row_d       = row_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The done cycle still belongs to the finished tile.
                if (bus.start && !done_q) begin
                    state_d = CLEAR;
                    k_len_d = bus.k_len;
                end
            end
            CLEAR: begin
                beat_cnt_d  = '0;
                flush_cnt_d = '0;
                row_d       = '0;
                state_d     = (k_len_q == '0) ? FLUSH : FEED;
            end
            FEED: begin
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == k_len_q - 1'b1) state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == FLUSH_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                if (row_fire) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.in_ready  = (state_q == FEED);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_row   = row_q;
    assign bus.done      = done_q;

    logic [DATA_WIDTH-1:0]         h_data  [ROWS][COLS+1];
    logic                          h_valid [ROWS][COLS+1];
    logic [DATA_WIDTH-1:0]         v_data  [ROWS+1][COLS];
    logic                          v_valid [ROWS+1][COLS];
    logic signed [ACCUM_WIDTH-1:0] acc     [ROWS][COLS];

    genvar gi, gj;
    generate
        // Beat valid rides with the data so bubbles never trigger a MAC.
        for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
            logic [DATA_WIDTH:0] lane_out;
            skew_delay_line #(.WIDTH(DATA_WIDTH + 1), .DEPTH(gi)) u_skew (
                .clk  (clk),
                .rst  (rst),
                .in_i ({beat_fire, bus.a_col[gi*DATA_WIDTH +: DATA_WIDTH]}),
                .out_o(lane_out)
            );
            assign h_valid[gi][0] = lane_out[DATA_WIDTH];
            assign h_data[gi][0]  = lane_out[DATA_WIDTH-1:0];
        end

        for (gi = 0; gi < COLS; gi++) begin : g_b_skew
            logic [DATA_WIDTH:0] lane_out;
            skew_delay_line #(.WIDTH(DATA_WIDTH + 1), .DEPTH(gi)) u_skew (
                .clk  (clk),
                .rst  (rst),
                .in_i ({beat_fire, bus.b_row[gi*DATA_WIDTH +: DATA_WIDTH]}),
                .out_o(lane_out)
            );
            assign v_valid[0][gi] = lane_out[DATA_WIDTH];
            assign v_data[0][gi]  = lane_out[DATA_WIDTH-1:0];
        end

        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                pe_int8 #(.DATA_WIDTH(DATA_WIDTH), .ACCUM_WIDTH(ACCUM_WIDTH)) u_pe (
                    .clk          (clk),
                    .rst          (rst),
                    .accum_reset_i(accum_clear),
                    .west_data_i  (h_data[gi][gj]),
                    .west_valid_i (h_valid[gi][gj]),
                    .north_data_i (v_data[gi][gj]),
                    .north_valid_i(v_valid[gi][gj]),
                    .east_data_o  (h_data[gi][gj+1]),
                    .east_valid_o (h_valid[gi][gj+1]),
                    .south_data_o (v_data[gi+1][gj]),
                    .south_valid_o(v_valid[gi+1][gj]),
                    .acc_o        (acc[gi][gj])
                );
            end
        end

        for (gi = 0; gi < COLS; gi++) begin : g_out
            assign bus.out_data[gi*ACCUM_WIDTH +: ACCUM_WIDTH] = acc[row_q][gi];
        end
    endgenerate

    // Operands leaving the far edges of the grid have no consumer.
    logic unused_edge;
    always_comb begin
        unused_edge = 1'b0;
        for (int r = 0; r < ROWS; r++)
            unused_edge = unused_edge ^ (^{h_data[r][COLS], h_valid[r][COLS]});
        for (int c = 0; c < COLS; c++)
            unused_edge = unused_edge ^ (^{v_data[ROWS][c], v_valid[ROWS][c]});
    end
endmodule

// File: tb/tb_systolic_array_ctrl_nxm.sv
// Directed bench for the GEMM tile engine on a non-square 4x8 grid.
module tb_systolic_array_ctrl_nxm;
    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int DW    = 8;
    localparam int AW    = 32;
    localparam int K_MAX = 512;
    localparam int KW    = $clog2(K_MAX + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_array_ctrl_nxm_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW),
                                 .ACCUM_WIDTH(AW), .K_MAX(K_MAX)) bus ();

    systolic_array_ctrl_nxm #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW),
                              .ACCUM_WIDTH(AW), .K_MAX(K_MAX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int a_m    [ROWS][K_MAX];
    int b_m    [K_MAX][COLS];
    int gold_m [ROWS][COLS];
    int res_m  [ROWS][COLS];

    int n_checks = 0;
    int n_fail   = 0;

    bit timeout_hit, row_bad, stall_changed, in_ready_seen;
    int done_cnt, stall_seen, rows_got;
    logic busy_after, done_after;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pat(input int i, input int j, input int s);
        return ((i * 37 + j * 11 + s * 5 + 3) % 256) - 128;
    endfunction

    task automatic load_pattern(input int k, input int s);
        for (int r = 0; r < ROWS; r++)
            for (int kk = 0; kk < k; kk++) a_m[r][kk] = pat(r, kk, s);
        for (int kk = 0; kk < k; kk++)
            for (int c = 0; c < COLS; c++) b_m[kk][c] = pat(kk, c, s + 7);
    endtask

    task automatic compute_golden(input int k);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                gold_m[r][c] = 0;
                for (int kk = 0; kk < k; kk++) gold_m[r][c] += a_m[r][kk] * b_m[kk][c];
            end
    endtask

    task automatic drive_beat(input int beat);
        for (int r = 0; r < ROWS; r++) bus.a_col[r*DW +: DW] = DW'(a_m[r][beat]);
        for (int c = 0; c < COLS; c++) bus.b_row[c*DW +: DW] = DW'(b_m[beat][c]);
    endtask

    // Runs one tile from the current post-edge instant; records drained rows and
    // handshake observations for the calling test to judge.
    task automatic run_tile(input int k, input bit bubbles, input int stall_row,
                            input int stall_len, input bit hold_start);
        int beat, row, cyc, stall, snap_row;
        bit tog, drove;
        logic [COLS*AW-1:0] snap_data;
        beat = 0; row = 0; stall = 0; tog = 1'b1; cyc = 0;
        snap_row = 0; snap_data = '0;
        timeout_hit = 0; row_bad = 0; stall_changed = 0; in_ready_seen = 0;
        done_cnt = 0; stall_seen = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) res_m[r][c] = 32'h5A5A5A5A;
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        @(posedge clk); #1;
        bus.start = hold_start;
        while (done_cnt == 0 && cyc < 4000) begin
            drove = 1'b0;
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b0;
            if (bus.in_ready) begin
                in_ready_seen = 1'b1;
                if (!bubbles || tog) begin
                    drive_beat(beat);
                    bus.in_valid = 1'b1;
                    drove = 1'b1;
                end
                tog = !tog;
            end
            if (bus.out_valid) begin
                if (row == stall_row && stall < stall_len) begin
                    if (stall == 0) begin
                        snap_data = bus.out_data;
                        snap_row  = int'(bus.out_row);
                    end else if (bus.out_data !== snap_data || int'(bus.out_row) != snap_row) begin
                        stall_changed = 1'b1;
                    end
                    stall++;
                    stall_seen = stall;
                end else begin
                    if (stall > 0 && row == stall_row &&
                        (bus.out_data !== snap_data || int'(bus.out_row) != snap_row))
                        stall_changed = 1'b1;
                    bus.out_ready = 1'b1;
                    if (int'(bus.out_row) != row) row_bad = 1'b1;
                    if (row < ROWS)
                        for (int c = 0; c < COLS; c++)
                            res_m[row][c] = int'($signed(bus.out_data[c*AW +: AW]));
                    row++;
                end
            end
            @(posedge clk); #1;
            if (drove) beat++;
            if (bus.done) done_cnt++;
            cyc++;
        end
        if (done_cnt == 0) timeout_hit = 1'b1;
        rows_got = row;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        done_after = bus.done;
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.k_len = '0; bus.in_valid = 0; bus.out_ready = 0;
        bus.a_col = '0; bus.b_row = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.in_ready, bus.out_valid, bus.done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.in_ready, bus.out_valid, bus.done});
        end
        n_checks++;
        if (bus.out_row !== '0 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_out got row=%0d data=%h exp row=0 data=0", bus.out_row, bus.out_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy got=%b exp=0", bus.busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_beat();
        for (int r = 0; r < ROWS; r++) a_m[r][0] = r + 1;
        for (int c = 0; c < COLS; c++) b_m[0][c] = 1;
        run_tile(1, 0, -1, 0, 0);
        n_checks++;
        if (timeout_hit || done_cnt != 1 || rows_got != ROWS || row_bad) begin
            n_fail++;
            $display("FAIL k1_flow got timeout=%0d done=%0d rows=%0d rowbad=%0d exp 0/1/%0d/0",
                     timeout_hit, done_cnt, rows_got, row_bad, ROWS);
        end
        n_checks++;
        if (done_after !== 1'b0 || busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL k1_done_pulse got done=%b busy=%b exp 0 0", done_after, busy_after);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_checks++;
                if (res_m[r][c] != r + 1) begin
                    n_fail++;
                    $display("FAIL k1_data r=%0d c=%0d got=%0d exp=%0d", r, c, res_m[r][c], r + 1);
                end
            end
        $display("test_single_beat done");
    endtask

    task automatic test_identity_extremes();
        for (int r = 0; r < ROWS; r++)
            for (int kk = 0; kk < ROWS; kk++) a_m[r][kk] = (r == kk) ? 1 : 0;
        for (int kk = 0; kk < ROWS; kk++)
            for (int c = 0; c < COLS; c++) b_m[kk][c] = pat(kk, c, 2);
        run_tile(ROWS, 0, -1, 0, 0);
        n_checks++;
        if (timeout_hit || row_bad) begin
            n_fail++;
            $display("FAIL ident_flow got timeout=%0d rowbad=%0d exp 0 0", timeout_hit, row_bad);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_checks++;
                if (res_m[r][c] != b_m[r][c]) begin
                    n_fail++;
                    $display("FAIL ident r=%0d c=%0d got=%0d exp=%0d", r, c, res_m[r][c], b_m[r][c]);
                end
            end
        for (int r = 0; r < ROWS; r++)
            for (int kk = 0; kk < 16; kk++) a_m[r][kk] = -128;
        for (int kk = 0; kk < 16; kk++)
            for (int c = 0; c < COLS; c++) b_m[kk][c] = (c % 2 == 0) ? -128 : 127;
        run_tile(16, 0, -1, 0, 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_checks++;
                if (res_m[r][c] != ((c % 2 == 0) ? 262144 : -260096)) begin
                    n_fail++;
                    $display("FAIL extreme r=%0d c=%0d got=%0d exp=%0d", r, c, res_m[r][c],
                             (c % 2 == 0) ? 262144 : -260096);
                end
            end
        $display("test_identity_extremes done");
    endtask

    task automatic test_bubbles_stall();
        load_pattern(4, 11);
        compute_golden(4);
        run_tile(4, 1, 2, 3, 0);
        n_checks++;
        if (timeout_hit || row_bad || stall_seen != 3 || stall_changed) begin
            n_fail++;
            $display("FAIL stall got timeout=%0d rowbad=%0d stalls=%0d changed=%0d exp 0 0 3 0",
                     timeout_hit, row_bad, stall_seen, stall_changed);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_checks++;
                if (res_m[r][c] != gold_m[r][c]) begin
                    n_fail++;
                    $display("FAIL bubble r=%0d c=%0d got=%0d exp=%0d", r, c, res_m[r][c], gold_m[r][c]);
                end
            end
        $display("test_bubbles_stall done");
    endtask

    task automatic test_zero_k();
        run_tile(0, 0, -1, 0, 0);
        n_checks++;
        if (timeout_hit || done_cnt != 1 || in_ready_seen) begin
            n_fail++;
            $display("FAIL k0_flow got timeout=%0d done=%0d in_ready_seen=%0d exp 0 1 0",
                     timeout_hit, done_cnt, in_ready_seen);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_checks++;
                if (res_m[r][c] != 0) begin
                    n_fail++;
                    $display("FAIL k0_data r=%0d c=%0d got=%0d exp=0", r, c, res_m[r][c]);
                end
            end
        $display("test_zero_k done");
    endtask

    task automatic test_abort();
        int cyc, beat, dn, busy_seen;
        load_pattern(4, 21);
        bus.start = 1'b1;
        bus.k_len = KW'(4);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0; beat = 0;
        while (beat < 2 && cyc < 50) begin
            bus.in_valid = 1'b0;
            if (bus.in_ready) begin
                drive_beat(beat);
                bus.in_valid = 1'b1;
            end
            @(posedge clk); #1;
            if (bus.in_valid) beat++;
            cyc++;
        end
        n_checks++;
        if (beat != 2) begin
            n_fail++;
            $display("FAIL abort_feed got beats=%0d exp=2", beat);
        end
        drive_beat(2);
        bus.in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.busy, bus.out_valid, bus.in_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_state got=%b exp=000", {bus.busy, bus.out_valid, bus.in_ready});
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        dn = 0; busy_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) dn++;
            if (bus.busy) busy_seen++;
        end
        n_checks++;
        if (dn != 0 || busy_seen != 0) begin
            n_fail++;
            $display("FAIL abort_quiet got done=%0d busy=%0d exp 0 0", dn, busy_seen);
        end
        load_pattern(3, 33);
        compute_golden(3);
        run_tile(3, 0, -1, 0, 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_checks++;
                if (res_m[r][c] != gold_m[r][c]) begin
                    n_fail++;
                    $display("FAIL abort_fresh r=%0d c=%0d got=%0d exp=%0d", r, c, res_m[r][c], gold_m[r][c]);
                end
            end
        $display("test_abort done");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < ROWS; r++)
            for (int kk = 0; kk < 300; kk++) a_m[r][kk] = 127;
        for (int kk = 0; kk < 300; kk++)
            for (int c = 0; c < COLS; c++) b_m[kk][c] = (c % 2 == 0) ? 127 : -127;
        run_tile(300, 0, -1, 0, 1);
        n_checks++;
        if (timeout_hit || done_cnt != 1 || busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first got timeout=%0d done=%0d busy_after=%b exp 0 1 0",
                     timeout_hit, done_cnt, busy_after);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_checks++;
                if (res_m[r][c] != ((c % 2 == 0) ? 4838700 : -4838700)) begin
                    n_fail++;
                    $display("FAIL k300 r=%0d c=%0d got=%0d exp=%0d", r, c, res_m[r][c],
                             (c % 2 == 0) ? 4838700 : -4838700);
                end
            end
        load_pattern(5, 44);
        compute_golden(5);
        run_tile(5, 0, -1, 0, 0);
        n_checks++;
        if (timeout_hit || done_cnt != 1 || row_bad) begin
            n_fail++;
            $display("FAIL b2b_second got timeout=%0d done=%0d rowbad=%0d exp 0 1 0",
                     timeout_hit, done_cnt, row_bad);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_checks++;
                if (res_m[r][c] != gold_m[r][c]) begin
                    n_fail++;
                    $display("FAIL b2b r=%0d c=%0d got=%0d exp=%0d", r, c, res_m[r][c], gold_m[r][c]);
                end
            end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_identity_extremes();
        test_bubbles_stall();
        test_zero_k();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
